// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: loaded with the round-10 key, it streams round keys 10..0
// to the inverse-round engine, one per accepted handshake, using a local logic S-box.
module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] last_key,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [0:127] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_w, sub_w;
    logic [0:127] prev_key;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Undo one forward expansion step: recover the previous round key from the current one.
    always_comb begin
        k0       = key_q[0:31];
        k1       = key_q[32:63];
        k2       = key_q[64:95];
        k3       = key_q[96:127];
        p3       = k3 ^ k2;
        p2       = k2 ^ k1;
        p1       = k1 ^ k0;
        rot_w    = {p3[23:0], p3[31:24]};
        sub_w    = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        p0       = k0 ^ sub_w ^ {rcon(idx_q), 24'h0};
        prev_key = {p0, p1, p2, p3};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    idx_d   = 4'(NR);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (idx_q != 4'd0) begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule: FIPS-197 vectors plus a forward-expansion model
// for random keys; one task per scenario, inputs driven and outputs sampled on the falling edge.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         key_ready;
    logic [127:0] last_key;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [127:0] A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] C0  = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] exp_a [0:10];
    logic [127:0] exp_m [0:10];
    logic [7:0]   sb    [0:255];

    always #5 clk = ~clk;

    aes_inv_key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    // S-box table from an exhaustive inverse search and the bitwise affine definition.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sb[a] = s;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_m[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic init_vectors();
        exp_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_a[10] = A10;
    endtask

    // Called on a falling edge; returns on the next falling edge with the idx10 key visible.
    task automatic kick(input logic [127:0] k);
        start    = 1'b1;
        last_key = k;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key_ready = 1'b0; last_key = '0;
        @(negedge clk);
        n_cmp++;
        if (round_key !== 128'h0 || round_idx !== 4'd0) begin
            n_fail++; $display("FAIL reset_data: key=%h idx=%0d, required 0/0", round_key, round_idx);
        end
        n_cmp++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, required 0/0/0", key_valid, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: valid=%b busy=%b, required 0/0", key_valid, busy);
        end
    endtask

    task automatic test_stream();
        key_ready = 1'b1;
        kick(A10);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy: busy=%b, required 1", busy); end
        for (int r = 10; r >= 0; r--) begin
            n_cmp++;
            if (key_valid !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_a[r]) begin
                n_fail++;
                $display("FAIL stream_r%0d: v=%b idx=%0d key=%h, required v=1 idx=%0d key=%h",
                         r, key_valid, round_idx, round_key, r, exp_a[r]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_done: done=%b busy=%b valid=%b, required 1/0/0", done, busy, key_valid);
        end
        n_cmp++;
        if (round_idx !== 4'd0 || round_key !== exp_a[0]) begin
            n_fail++; $display("FAIL stream_hold_last: idx=%0d key=%h, required 0 %h", round_idx, round_key, exp_a[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: done=%b, required 0", done); end
    endtask

    task automatic test_stall();
        int           acc;
        int           cyc;
        logic         held;
        logic         kr;
        logic [127:0] pk;
        logic [3:0]   pi;
        acc = 0; cyc = 0; held = 1'b0; pk = '0; pi = '0;
        key_ready = 1'b1;
        kick(A10);
        while (acc < 11 && cyc < 300) begin
            if (held) begin
                n_cmp++;
                if (round_key !== pk || round_idx !== pi || key_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_hold: idx=%0d key=%h, required %0d %h", round_idx, round_key, pi, pk);
                end
            end
            kr = 1'($urandom_range(0, 1));
            key_ready = kr;
            if (kr) begin
                n_cmp++;
                if (key_valid !== 1'b1 || round_idx !== 4'(10 - acc) || round_key !== exp_a[10 - acc]) begin
                    n_fail++;
                    $display("FAIL stall_accept_%0d: v=%b idx=%0d key=%h, required idx=%0d key=%h",
                             acc, key_valid, round_idx, round_key, 10 - acc, exp_a[10 - acc]);
                end
                acc++;
                held = 1'b0;
            end else begin
                held = 1'b1; pk = round_key; pi = round_idx;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (acc != 11) begin n_fail++; $display("FAIL stall_timeout: accepted %0d keys, required 11", acc); end
        n_cmp++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: done=%b, required 1", done); end
        key_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        key_ready = 1'b1;
        kick(A10);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (round_idx !== 4'd5) begin n_fail++; $display("FAIL ign_at5: idx=%0d, required 5", round_idx); end
        kick(C10);
        for (int r = 4; r >= 0; r--) begin
            n_cmp++;
            if (key_valid !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_a[r]) begin
                n_fail++;
                $display("FAIL ign_r%0d: idx=%0d key=%h, required idx=%0d key=%h", r, round_idx, round_key, r, exp_a[r]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done: done=%b, required 1", done); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        key_ready = 1'b1;
        kick(A10);
        repeat (7) @(negedge clk);
        n_cmp++;
        if (round_idx !== 4'd3) begin n_fail++; $display("FAIL rst_at3: idx=%0d, required 3", round_idx); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (round_key !== 128'h0 || round_idx !== 4'd0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: key=%h idx=%0d v=%b busy=%b done=%b, required all 0",
                     round_key, round_idx, key_valid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || round_key !== 128'h0) begin
            n_fail++; $display("FAIL rst_no_partial: v=%b busy=%b key=%h, required 0/0/0", key_valid, busy, round_key);
        end
        kick(A10);
        for (int r = 10; r >= 0; r--) begin
            n_cmp++;
            if (key_valid !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_a[r]) begin
                n_fail++;
                $display("FAIL rst_rerun_r%0d: idx=%0d key=%h, required idx=%0d key=%h", r, round_idx, round_key, r, exp_a[r]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL rst_rerun_done: done=%b, required 1", done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        key_ready = 1'b1;
        kick(A10);
        repeat (11) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_a: done=%b, required 1", done); end
        kick(C10);
        n_cmp++;
        if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== C10 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_c10: v=%b idx=%0d key=%h busy=%b, required 1 10 %h 1", key_valid, round_idx, round_key, busy, C10);
        end
        repeat (9) @(negedge clk);
        n_cmp++;
        if (round_idx !== 4'd1 || round_key !== C1) begin
            n_fail++; $display("FAIL b2b_c1: idx=%0d key=%h, required 1 %h", round_idx, round_key, C1);
        end
        @(negedge clk);
        n_cmp++;
        if (round_idx !== 4'd0 || round_key !== C0) begin
            n_fail++; $display("FAIL b2b_c0: idx=%0d key=%h, required 0 %h", round_idx, round_key, C0);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_c: done=%b, required 1", done); end
        @(negedge clk);
        kick(A10);
        n_cmp++;
        if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== A10) begin
            n_fail++; $display("FAIL b2b_after_done: v=%b idx=%0d key=%h, required 1 10 %h", key_valid, round_idx, round_key, A10);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_xcheck();
        logic [127:0] k;
        key_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            kick(exp_m[10]);
            for (int r = 10; r >= 0; r--) begin
                n_cmp++;
                if (key_valid !== 1'b1 || round_idx !== 4'(r) || round_key !== exp_m[r]) begin
                    n_fail++;
                    $display("FAIL xcheck_%0d_r%0d: idx=%0d key=%h, required idx=%0d key=%h",
                             n, r, round_idx, round_key, r, exp_m[r]);
                end
                @(negedge clk);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        build_sbox();
        init_vectors();
        test_reset();
        test_stream();
        test_stall();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        test_xcheck();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Reverse-direction AES-128 key schedule for the decrypt datapath. It is loaded with the final round key (round 10) and regenerates the round keys in decryption order, 10 down to 0. Keys are produced one per accepted handshake using the inverse recurrence of the forward key expansion. This avoids storing the full 1408-bit schedule on the decrypt side, and it streams keys directly to the inverse-round engine.

Parameters:
NR, 10, number of AES rounds. Fixed for AES-128; other values are unsupported.

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  load request; sampled only in IDLE
last_key  in  [0:127]  round-10 key; bit 0 is the MSB of byte 0; sampled on an accepted start
round_key  out  [0:127]  current round key, same bit order as last_key
round_idx  out  [3:0]  round number of round_key (10 down to 0)
key_valid  out  1  round_key/round_idx are valid
key_ready  in  1  consumer accepts round_key when key_valid and key_ready are both high
busy  out  1  high from an accepted start until the round-0 key is accepted
done  out  1  single-cycle pulse after the round-0 key is accepted

Behaviour:
- Reset (async, rst=1): state=IDLE; round_key=0; round_idx=0; key_valid=0; busy=0; done=0.
- FSM states: IDLE, EMIT.
- IDLE with start=1 at a clock edge:
  - round_key<=last_key; round_idx<=10; key_valid<=1; busy<=1; state<=EMIT.
  - First key is valid 1 cycle after start.
- EMIT, key_valid=1, key_ready=0: all outputs hold unchanged (no stepping).
- EMIT, accept with round_idx>0:
  - round_key<=inverse step of the current key; round_idx<=round_idx-1; key_valid stays 1.
  - Throughput is 1 key/cycle while key_ready stays high.
- EMIT, accept with round_idx=0:
  - key_valid<=0; busy<=0; done<=1 for exactly one cycle; state<=IDLE.
  - round_key and round_idx hold their last values.
- Inverse step (combinational, 32-bit words; k0..k3 = current key, p0..p3 = previous key):
  - p3=k3^k2; p2=k2^k1; p1=k1^k0.
  - p0=k0^SubWord(RotWord(p3))^{Rcon[round_idx],24'h0}.
  - Rcon[10..1]=36,1b,80,40,20,10,08,04,02,01 (hex).
  - RotWord is a 1-byte left rotate: [a,b,c,d]->[b,c,d,a].
  - SubWord applies the forward AES S-box to each byte. The S-box is implemented locally as a combinational GF(2^8) inverse followed by the affine transform; no table ROM.
- start while busy is ignored; the run in progress continues unchanged.
- start is accepted in the same cycle that done pulses: yes (state is already IDLE at that edge).
- The next start may be accepted the cycle after done.
- key_ready while key_valid=0 has no effect.
- Rcon for round_idx 0 or >10 is never used; the implementation may return 0 for these.
- rst asserted mid-run aborts immediately to the reset values. No partial key is presented after rst deasserts.

Test Plan:
- Reset then start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 held:
  - idx10 key equals last_key.
  - Next cycle: idx9=ac7766f319fadc2128d12941575c006e.
  - 11th valid cycle: idx0=2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses once; busy falls.
- Same vector with key_ready toggled pseudo-randomly: the sequence of accepted keys is identical; round_key and round_idx hold stable whenever key_ready=0.
- Assert start mid-run at idx 5 with a different last_key: ignored; the remaining keys still match the original key.
- Assert rst at idx 3: outputs are 0 asynchronously, before the next clk edge. A new start afterwards produces the full correct 11-key sequence.
- Back-to-back runs: start in the done cycle with last_key=13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197 C.1, key 000102...0f). idx0 returns 000102030405060708090a0b0c0d0e0f.
- Cross-check against the forward aes_key_expansion: feed a random key forward, take schedule bits [1280:1407] as last_key. The emitted keys equal the schedule slices in reverse order, for 100 random keys.
